// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and the
// upper bound of the populated address range on the register-file slave.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_W   = 8;
  localparam int APB_DATA_W   = 8;
  // Addresses at or above this value are unpopulated and answer with pslverr.
  localparam int APB_ADDR_MAX = 200;

endpackage

// File: rtl/apb_rr_master_arbiter.sv
// Combinational round-robin arbiter. Searches upward from ptr+1 (mod N) and
// returns the first requester found. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int PW = $clog2(N);

  // Rotating priority search; lowest distance above ptr wins.
  always_comb begin
    int idx;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx        = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any             = 1'b1;
        gnt_idx         = idx[PW-1:0];
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NREQ local requesters onto one APB slave
// port, runs SETUP/ACCESS with a pready timeout and returns the response to
// the granted requester as a one-cycle pulse.
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                     pclk,
  input  logic                     prst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [ADDR_W-1:0]        paddr,
  output logic [DATA_W-1:0]        pwdata,
  input  logic [DATA_W-1:0]        prdata,
  input  logic                     pready,
  input  logic                     pslverr
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  apb_state_e        state, state_nxt;
  logic [PW-1:0]     ptr;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [NREQ-1:0]   gnt_onehot;
  logic [PW-1:0]     gnt_idx;
  logic              gnt_any;
  logic              timeout;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req        (req_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  // Last permitted ACCESS cycle; the counter never needs to go past it.
  assign timeout = (cnt == CW'(TIMEOUT - 1));

  // State register; reset aborts any transfer in flight.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_any) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (pready || timeout) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state so that reset clears psel/penable immediately.
  always_comb begin
    psel      = 1'b0;
    penable   = 1'b0;
    req_ready = '0;
    rsp_valid = '0;
    rsp_rdata = '0;
    rsp_err   = 1'b0;
    case (state)
      IDLE:   req_ready = gnt_onehot;
      SETUP:  psel = 1'b1;
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      RESP: begin
        rsp_valid[ptr] = 1'b1;
        rsp_rdata      = rdata_q;
        rsp_err        = err_q;
      end
      default: ;
    endcase
  end

  // Latch the winning request; address/data hold until the next grant.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      ptr    <= PW'(NREQ - 1);
      paddr  <= '0;
      pwrite <= 1'b0;
      pwdata <= '0;
    end else if (state == IDLE && gnt_any) begin
      ptr    <= gnt_idx;
      paddr  <= req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      pwrite <= req_write[gnt_idx];
      pwdata <= req_write[gnt_idx] ? req_wdata[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
    end
  end

  // Wait counter and response capture.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        SETUP: cnt <= '0;
        ACCESS: begin
          if (pready) begin
            rdata_q <= pwrite ? '0 : prdata;
            err_q   <= pslverr;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master with a small register-file slave model.
module tb_apb_rr_master;
  import apb_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 8;
  localparam int DW   = 8;

  logic              pclk, prst;
  logic [NREQ-1:0]   req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0]     rsp_rdata, pwdata, prdata;
  logic [AW-1:0]     paddr;
  logic              rsp_err, psel, penable, pwrite, pready, pslverr;

  int checks = 0;
  int failures = 0;

  apb_rr_master #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .pclk(pclk), .prst(prst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Slave model: memory below APB_ADDR_MAX, error above, programmable waits.
  logic [DW-1:0] mem [256];
  int  wait_cfg = 0;
  bit  hang = 1'b0;
  int  sacc = 0;

  assign pready  = psel && penable && !hang && (sacc >= wait_cfg);
  assign prdata  = (int'(paddr) < APB_ADDR_MAX) ? mem[paddr] : 8'h00;
  assign pslverr = pready && (int'(paddr) >= APB_ADDR_MAX);

  always @(posedge pclk) begin
    if (psel && penable && !pready) sacc <= sacc + 1;
    else                            sacc <= 0;
    if (psel && penable && pready && pwrite && int'(paddr) < APB_ADDR_MAX)
      mem[paddr] <= pwdata;
  end

  // Bus monitor sampling on the falling edge.
  int cyc = 0;
  int acc_cycles = 0, rsp_cnt = 0, unstable = 0, slverr_cnt = 0;
  int ready_cyc = 0, rsp_cyc = 0;
  logic [AW-1:0] setup_addr = '0;

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (psel && !penable) setup_addr <= paddr;
    if (psel && penable) begin
      acc_cycles <= acc_cycles + 1;
      if (paddr !== setup_addr) unstable <= unstable + 1;
      if (pslverr) slverr_cnt <= slverr_cnt + 1;
      if (pready) ready_cyc <= cyc;
    end
    if (rsp_valid != '0) begin
      rsp_cnt <= rsp_cnt + 1;
      rsp_cyc <= cyc;
    end
  end

  task automatic do_reset();
    prst = 1'b1;
    req_valid = '0;
    @(posedge pclk); @(posedge pclk); #1;
    prst = 1'b0;
  endtask

  task automatic set_req(input int i, input bit w, input logic [7:0] a, input logic [7:0] d);
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
  endtask

  // One complete transfer from requester i; ok=0 if any bound expired.
  task automatic xfer(input int i, input bit w, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic er, output bit ok);
    int n;
    ok = 1'b0; rd = '0; er = 1'b0;
    set_req(i, w, a, d);
    #1;
    n = 0;
    while (!req_ready[i] && n < 50) begin @(posedge pclk); #1; n++; end
    if (!req_ready[i]) begin req_valid[i] = 1'b0; return; end
    @(posedge pclk); #1;
    req_valid[i] = 1'b0;
    n = 0;
    while (!rsp_valid[i] && n < 100) begin @(posedge pclk); #1; n++; end
    if (rsp_valid[i]) begin rd = rsp_rdata; er = rsp_err; ok = 1'b1; end
    @(posedge pclk); #1;
  endtask

  // Record grant order while requesters drop valid after their accept edge.
  task automatic collect(input int nexp, output int order[8], output int cnt);
    logic [NREQ-1:0] last;
    cnt = 0;
    for (int k = 0; k < 8; k++) order[k] = -1;
    #1;
    for (int c = 0; c < 80 && cnt < nexp; c++) begin
      last = req_ready;
      @(posedge pclk); #1;
      if (last != '0) begin
        for (int j = 0; j < NREQ; j++)
          if (last[j]) begin order[cnt] = j; req_valid[j] = 1'b0; end
        cnt++;
      end
    end
    repeat (4) @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    prst = 1'b1;
    #1;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h rdy=%b rsp=%b rdata=%h err=%b, want all 0",
               psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    @(posedge pclk); @(posedge pclk); #1;
    prst = 1'b0;
  endtask

  task automatic test_single_write();
    logic [7:0] rd; logic er; bit ok;
    set_req(0, 1'b1, 8'h10, 8'hA5);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL sw_ready_c0: got %b want 0001", req_ready); end
    @(posedge pclk); #1;
    req_valid[0] = 1'b0;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {1'b1, 1'b0, 1'b1, 8'h10, 8'hA5}) begin
      failures++;
      $display("FAIL sw_setup_c1: got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h want 1 0 1 10 a5",
               psel, penable, pwrite, paddr, pwdata);
    end
    @(posedge pclk); #1;
    checks++;
    if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL sw_access_c2: got psel=%b pen=%b want 1 1", psel, penable); end
    @(posedge pclk); #1;
    checks++;
    if ({rsp_valid, rsp_err, psel, penable} !== {4'b0001, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL sw_resp_c3: got rsp=%b err=%b psel=%b pen=%b want 0001 0 0 0", rsp_valid, rsp_err, psel, penable);
    end
    @(posedge pclk); #1;
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      failures++;
      $display("FAIL sw_after_resp: got rsp=%b rdata=%h err=%b want 0", rsp_valid, rsp_rdata, rsp_err);
    end
    xfer(0, 1'b0, 8'h10, 8'hFF, rd, er, ok);
    checks++;
    if (!ok || rd !== 8'hA5 || er !== 1'b0) begin
      failures++;
      $display("FAIL sw_readback: got ok=%0d rdata=%h err=%b want 1 a5 0", ok, rd, er);
    end
  endtask

  task automatic test_all_four();
    int order[8]; int cnt;
    logic [7:0] rd; logic er; bit ok;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(8'h20 + i), 8'(i));
    collect(4, order, cnt);
    for (int i = 0; i < NREQ; i++) begin
      checks++;
      if (order[i] != i) begin failures++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i); end
    end
    for (int i = 0; i < NREQ; i++) begin
      xfer(i, 1'b0, 8'(8'h20 + i), 8'h00, rd, er, ok);
      checks++;
      if (!ok || rd !== 8'(i) || er !== 1'b0) begin
        failures++;
        $display("FAIL rr_read[%0d]: got ok=%0d rdata=%h err=%b want 1 %h 0", i, ok, rd, er, 8'(i));
      end
    end
  endtask

  task automatic test_slverr();
    logic [7:0] rd; logic er; bit ok;
    int s0;
    s0 = slverr_cnt;
    xfer(0, 1'b1, 8'hF0, 8'h5A, rd, er, ok);
    checks++;
    if (!ok || er !== 1'b1 || slverr_cnt - s0 != 1) begin
      failures++;
      $display("FAIL oor_write: got ok=%0d err=%b slverr_seen=%0d want 1 1 1", ok, er, slverr_cnt - s0);
    end
    xfer(1, 1'b0, 8'hF0, 8'h00, rd, er, ok);
    checks++;
    if (!ok || rd !== 8'h00 || er !== 1'b1) begin
      failures++;
      $display("FAIL oor_read: got ok=%0d rdata=%h err=%b want 1 00 1", ok, rd, er);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] rd; logic er; bit ok;
    int a0;
    hang = 1'b1;
    a0 = acc_cycles;
    xfer(1, 1'b0, 8'h10, 8'h00, rd, er, ok);
    hang = 1'b0;
    checks++;
    if (!ok || rd !== 8'h00 || er !== 1'b1) begin
      failures++;
      $display("FAIL timeout_rsp: got ok=%0d rdata=%h err=%b want 1 00 1", ok, rd, er);
    end
    checks++;
    if (acc_cycles - a0 != 16) begin failures++; $display("FAIL timeout_len: got %0d ACCESS cycles want 16", acc_cycles - a0); end
    xfer(1, 1'b0, 8'h10, 8'h00, rd, er, ok);
    checks++;
    if (!ok || rd !== 8'hA5 || er !== 1'b0) begin
      failures++;
      $display("FAIL timeout_recover: got ok=%0d rdata=%h err=%b want 1 a5 0", ok, rd, er);
    end
  endtask

  task automatic test_reset_mid();
    int order[8]; int cnt; int n; int r0;
    hang = 1'b1;
    set_req(2, 1'b1, 8'h30, 8'h77);
    #1;
    n = 0;
    while (!req_ready[2] && n < 20) begin @(posedge pclk); #1; n++; end
    @(posedge pclk); #1;
    req_valid[2] = 1'b0;
    @(posedge pclk); #1;
    checks++;
    if ({psel, penable} !== 2'b11) begin failures++; $display("FAIL rm_in_access: got psel=%b pen=%b want 1 1", psel, penable); end
    r0 = rsp_cnt;
    #1;
    prst = 1'b1;
    #1;
    checks++;
    if ({psel, penable} !== 2'b00) begin failures++; $display("FAIL rm_async_drop: got psel=%b pen=%b want 0 0", psel, penable); end
    hang = 1'b0;
    set_req(3, 1'b0, 8'h23, 8'h00);
    set_req(0, 1'b0, 8'h20, 8'h00);
    @(posedge pclk); @(posedge pclk); #1;
    checks++;
    if (rsp_valid !== '0 || rsp_cnt != r0) begin
      failures++;
      $display("FAIL rm_no_rsp: got rsp=%b pulses=%0d want 0000 0", rsp_valid, rsp_cnt - r0);
    end
    prst = 1'b0;
    collect(2, order, cnt);
    checks++;
    if (order[0] != 0 || order[1] != 3) begin
      failures++;
      $display("FAIL rm_grant_order: got %0d,%0d want 0,3", order[0], order[1]);
    end
    checks++;
    if (rsp_cnt - r0 != 2) begin failures++; $display("FAIL rm_rsp_count: got %0d want 2", rsp_cnt - r0); end
  endtask

  task automatic test_wait_states();
    logic [7:0] rd; logic er; bit ok;
    int a0, u0;
    wait_cfg = 3;
    a0 = acc_cycles;
    u0 = unstable;
    xfer(2, 1'b0, 8'h10, 8'h00, rd, er, ok);
    wait_cfg = 0;
    checks++;
    if (!ok || rd !== 8'hA5 || er !== 1'b0) begin
      failures++;
      $display("FAIL ws_read: got ok=%0d rdata=%h err=%b want 1 a5 0", ok, rd, er);
    end
    checks++;
    if (acc_cycles - a0 != 4) begin failures++; $display("FAIL ws_access_len: got %0d want 4", acc_cycles - a0); end
    checks++;
    if (unstable != u0) begin failures++; $display("FAIL ws_paddr_stable: got %0d changes want 0", unstable - u0); end
    checks++;
    if (rsp_cyc - ready_cyc != 1) begin failures++; $display("FAIL ws_rsp_latency: got %0d want 1", rsp_cyc - ready_cyc); end
  endtask

  initial begin
    prst = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    #2;
    test_reset();
    test_single_write();
    test_all_four();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_wait_states();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
